apb_req_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer in front of the APB master subsystem; shares its single command port between two internal clients.
- Accepts one command at a time, drives transfer/READ_WRITE/address/data stable for the whole APB transaction, and waits for completion or timeout.
- Returns read data and error status to the granted requester as a one-cycle done pulse.

---
 rtl/apb_req_arbiter_if.sv | 55 +++++
 rtl/apb_req_arbiter.sv | 158 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_arbiter_if.sv
// Purpose: bundles both requester command/response channels and the APB master command port.
// Latency: n/a (signal bundle only).
// Backpressure: reqN_valid/reqN_ready handshake per requester; APB side completes on apb_xfer_done.
// Ports (slave = arbiter view):
//   reqN_valid/write/addr/wdata in, reqN_ready/done/rdata/err out (N = 0, 1)
//   transfer/READ_WRITE/apb_write_paddr/apb_write_data/apb_read_paddr out to the APB master
//   apb_xfer_done/PSLVERR/apb_read_data_out in from the APB master
interface apb_req_arbiter_if;
    logic       req0_valid;
    logic       req0_write;
    logic [8:0] req0_addr;
    logic [7:0] req0_wdata;
    logic       req0_ready;
    logic       req0_done;
    logic [7:0] req0_rdata;
    logic       req0_err;

    logic       req1_valid;
    logic       req1_write;
    logic [8:0] req1_addr;
    logic [7:0] req1_wdata;
    logic       req1_ready;
    logic       req1_done;
    logic [7:0] req1_rdata;
    logic       req1_err;

    logic       transfer;
    logic       READ_WRITE;
    logic [8:0] apb_write_paddr;
    logic [7:0] apb_write_data;
    logic [8:0] apb_read_paddr;
    logic       apb_xfer_done;
    logic       PSLVERR;
    logic [7:0] apb_read_data_out;

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, req0_done, req0_rdata, req0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, req1_done, req1_rdata, req1_err,
        output transfer, READ_WRITE, apb_write_paddr, apb_write_data, apb_read_paddr,
        input  apb_xfer_done, PSLVERR, apb_read_data_out
    );

    // Environment side: requesters plus the APB master.
    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, req0_done, req0_rdata, req0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, req1_done, req1_rdata, req1_err,
        input  transfer, READ_WRITE, apb_write_paddr, apb_write_data, apb_read_paddr,
        output apb_xfer_done, PSLVERR, apb_read_data_out
    );
endinterface

// File: rtl/apb_req_arbiter.sv
// Purpose: two-requester round-robin arbiter/sequencer sharing one APB master command port.
// Latency: handshake at edge k -> transfer from k+1; done pulses the cycle after apb_xfer_done (or timeout).
// Backpressure: one command in flight; reqN_ready is only ever raised in IDLE, for the winner.
// Ports: PCLK, PRESETn (async active-low), bus (apb_req_arbiter_if.slave) carrying both
//   requester channels and the APB master command/completion signals.
module apb_req_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_req_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];

    state_t           state_q, state_d;
    logic             gnt_q;       // latched winner ID
    logic             prio_q;      // requester favoured when both are valid
    logic             wr_q;
    logic [8:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       rdata0_q, rdata1_q;
    logic             err0_q, err1_q;

    logic             any_vld;
    logic             win;
    logic             hs;
    logic             timeout_hit;
    logic             cap_en;
    logic             cap_err;
    logic [7:0]       cap_rdata;
    logic             busy;
    logic             busy_wr;
    logic             busy_rd;

    assign any_vld = bus.req0_valid | bus.req1_valid;

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end else begin : g_timeout
            assign timeout_hit = (cnt_q == TO_LAST);
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        win            = 1'b0;
        hs             = 1'b0;
        cap_en         = 1'b0;
        cap_err        = 1'b0;
        cap_rdata      = 8'd0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    win = prio_q;
                end else begin
                    win = bus.req1_valid;
                end
                // Ready is gated by reset so it reads 0 while PRESETn is low.
                if (any_vld && PRESETn) begin
                    hs             = 1'b1;
                    state_d        = BUSY;
                    bus.req0_ready = ~win;
                    bus.req1_ready = win;
                end
            end
            BUSY: begin
                // A completion landing on the timeout cycle takes precedence.
                if (bus.apb_xfer_done) begin
                    cap_en    = 1'b1;
                    cap_err   = bus.PSLVERR;
                    cap_rdata = wr_q ? 8'd0 : bus.apb_read_data_out;
                    state_d   = RESP;
                end else if (timeout_hit) begin
                    cap_en    = 1'b1;
                    cap_err   = 1'b1;
                    cap_rdata = 8'd0;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            prio_q   <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= 9'd0;
            wdata_q  <= 8'd0;
            cnt_q    <= '0;
            rdata0_q <= 8'd0;
            rdata1_q <= 8'd0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                gnt_q   <= win;
                wr_q    <= win ? bus.req1_write : bus.req0_write;
                addr_q  <= win ? bus.req1_addr  : bus.req0_addr;
                wdata_q <= win ? bus.req1_wdata : bus.req0_wdata;
                cnt_q   <= '0;
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // Response registers update on the BUSY->RESP edge so they are valid with done;
            // the other requester's copy holds.
            if (cap_en) begin
                if (gnt_q) begin
                    rdata1_q <= cap_rdata;
                    err1_q   <= cap_err;
                end else begin
                    rdata0_q <= cap_rdata;
                    err0_q   <= cap_err;
                end
            end
            if (state_q == RESP) begin
                prio_q <= ~gnt_q;
            end
        end
    end

    // Command outputs decode purely from flops, so they stay stable through BUSY
    // and drop to 0 the moment reset asserts.
    assign busy    = (state_q == BUSY);
    assign busy_wr = busy &  wr_q;
    assign busy_rd = busy & ~wr_q;

    assign bus.transfer        = busy;
    assign bus.READ_WRITE      = busy_rd;
    assign bus.apb_write_paddr = busy_wr ? addr_q  : 9'd0;
    assign bus.apb_write_data  = busy_wr ? wdata_q : 8'd0;
    assign bus.apb_read_paddr  = busy_rd ? addr_q  : 9'd0;

    assign bus.req0_done  = (state_q == RESP) & ~gnt_q;
    assign bus.req1_done  = (state_q == RESP) &  gnt_q;
    assign bus.req0_rdata = rdata0_q;
    assign bus.req1_rdata = rdata1_q;
    assign bus.req0_err   = err0_q;
    assign bus.req1_err   = err1_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Purpose: directed self-checking bench for apb_req_arbiter (TIMEOUT=16).
// Latency: drives inputs on the falling edge, samples outputs there too.
// Backpressure: requesters hold valid until ready; APB completion is pulsed by hand.
module tb_apb_req_arbiter;

    logic PCLK = 1'b0;
    logic PRESETn;

    int n_cmp    = 0;
    int n_err    = 0;
    int d0_cnt   = 0;
    int d1_cnt   = 0;
    int dual_cnt = 0;
    int xfer_cyc = 0;
    int snap0    = 0;
    int snap1    = 0;

    apb_req_arbiter_if bus();

    apb_req_arbiter #(
        .TIMEOUT (16),
        .CNT_W   (8)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    always #5 PCLK = ~PCLK;

    // Pulse/cycle monitor, sampled 3 time units after each rising edge.
    always begin
        @(posedge PCLK);
        #3;
        if (bus.req0_done) d0_cnt++;
        if (bus.req1_done) d1_cnt++;
        if (bus.req0_done && bus.req1_done) dual_cnt++;
        if (bus.transfer) xfer_cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge PCLK);
    endtask

    initial begin
        PRESETn               = 1'b0;
        bus.req0_valid        = 1'b0;
        bus.req0_write        = 1'b0;
        bus.req0_addr         = 9'd0;
        bus.req0_wdata        = 8'd0;
        bus.req1_valid        = 1'b0;
        bus.req1_write        = 1'b0;
        bus.req1_addr         = 9'd0;
        bus.req1_wdata        = 8'd0;
        bus.apb_xfer_done     = 1'b0;
        bus.PSLVERR           = 1'b0;
        bus.apb_read_data_out = 8'd0;

        // Reset state
        repeat (2) step();
        chk("rst_transfer", 16'(bus.transfer), 16'h0);
        chk("rst_rw",       16'(bus.READ_WRITE), 16'h0);
        chk("rst_wpaddr",   16'(bus.apb_write_paddr), 16'h0);
        chk("rst_rdata0",   16'(bus.req0_rdata), 16'h0);
        chk("rst_err1",     16'(bus.req1_err), 16'h0);
        chk("rst_done0",    16'(bus.req0_done), 16'h0);
        bus.req0_valid = 1'b1;
        #1;
        chk("rst_ready0",   16'(bus.req0_ready), 16'h0);
        bus.req0_valid = 1'b0;
        step();
        PRESETn = 1'b1;
        step();

        // Test 1: req0 write 0x005/0xA5, completion on the 3rd BUSY cycle
        xfer_cyc       = 0;
        bus.req0_valid = 1'b1;
        bus.req0_write = 1'b1;
        bus.req0_addr  = 9'h005;
        bus.req0_wdata = 8'hA5;
        #1;
        chk("t1_ready0", 16'(bus.req0_ready), 16'h1);
        chk("t1_ready1", 16'(bus.req1_ready), 16'h0);
        step();
        bus.req0_valid = 1'b0;
        chk("t1_transfer", 16'(bus.transfer), 16'h1);
        chk("t1_rw",       16'(bus.READ_WRITE), 16'h0);
        chk("t1_wpaddr",   16'(bus.apb_write_paddr), 16'h005);
        chk("t1_wdata",    16'(bus.apb_write_data), 16'h0A5);
        chk("t1_rpaddr",   16'(bus.apb_read_paddr), 16'h0);
        step();
        chk("t1_wpaddr_hold", 16'(bus.apb_write_paddr), 16'h005);
        step();
        bus.apb_xfer_done = 1'b1;
        step();
        bus.apb_xfer_done = 1'b0;
        chk("t1_done0",    16'(bus.req0_done), 16'h1);
        chk("t1_done1",    16'(bus.req1_done), 16'h0);
        chk("t1_err0",     16'(bus.req0_err), 16'h0);
        chk("t1_rdata0",   16'(bus.req0_rdata), 16'h0);
        chk("t1_xfer_off", 16'(bus.transfer), 16'h0);
        chk("t1_xfer_cyc", 16'(xfer_cyc), 16'd3);
        step();
        chk("t1_done0_off", 16'(bus.req0_done), 16'h0);
        chk("t1_d0_cnt",    16'(d0_cnt), 16'd1);

        // Test 2: req1 read 0x105 returning 0x3C
        bus.req1_valid = 1'b1;
        bus.req1_write = 1'b0;
        bus.req1_addr  = 9'h105;
        bus.req1_wdata = 8'h77;
        #1;
        chk("t2_ready1", 16'(bus.req1_ready), 16'h1);
        chk("t2_ready0", 16'(bus.req0_ready), 16'h0);
        step();
        bus.req1_valid = 1'b0;
        chk("t2_rw",     16'(bus.READ_WRITE), 16'h1);
        chk("t2_rpaddr", 16'(bus.apb_read_paddr), 16'h105);
        chk("t2_wpaddr", 16'(bus.apb_write_paddr), 16'h0);
        chk("t2_wdata",  16'(bus.apb_write_data), 16'h0);
        bus.apb_xfer_done     = 1'b1;
        bus.apb_read_data_out = 8'h3C;
        step();
        bus.apb_xfer_done     = 1'b0;
        bus.apb_read_data_out = 8'h00;
        chk("t2_done1",  16'(bus.req1_done), 16'h1);
        chk("t2_done0",  16'(bus.req0_done), 16'h0);
        chk("t2_rdata1", 16'(bus.req1_rdata), 16'h03C);
        chk("t2_err1",   16'(bus.req1_err), 16'h0);
        step();

        // Test 3: both valid for 4 commands, grants alternate 0,1,0,1
        bus.req0_valid = 1'b1;
        bus.req0_write = 1'b1;
        bus.req0_addr  = 9'h010;
        bus.req0_wdata = 8'h5A;
        bus.req1_valid = 1'b1;
        bus.req1_write = 1'b0;
        bus.req1_addr  = 9'h120;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t3_ready0_%0d", i), 16'(bus.req0_ready), 16'(i % 2 == 0));
            chk($sformatf("t3_ready1_%0d", i), 16'(bus.req1_ready), 16'(i % 2 == 1));
            chk($sformatf("t3_idle_xfer_%0d", i), 16'(bus.transfer), 16'h0);
            step();
            chk($sformatf("t3_busy_rdy_%0d", i), 16'({bus.req0_ready, bus.req1_ready}), 16'h0);
            chk($sformatf("t3_rw_%0d", i), 16'(bus.READ_WRITE), 16'(i % 2 == 1));
            bus.apb_xfer_done     = 1'b1;
            bus.apb_read_data_out = 8'(8'h50 + i);
            step();
            bus.apb_xfer_done     = 1'b0;
            chk($sformatf("t3_done0_%0d", i), 16'(bus.req0_done), 16'(i % 2 == 0));
            chk($sformatf("t3_done1_%0d", i), 16'(bus.req1_done), 16'(i % 2 == 1));
            chk($sformatf("t3_resp_rdy_%0d", i), 16'({bus.req0_ready, bus.req1_ready}), 16'h0);
            if (i % 2 == 1) begin
                chk($sformatf("t3_rdata1_%0d", i), 16'(bus.req1_rdata), 16'(8'h50 + i));
            end
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("t3_dual",   16'(dual_cnt), 16'd0);
        chk("t3_d0_cnt", 16'(d0_cnt), 16'd3);
        chk("t3_d1_cnt", 16'(d1_cnt), 16'd3);
        step();

        // Test 4: read with PSLVERR
        bus.req0_valid = 1'b1;
        bus.req0_write = 1'b0;
        bus.req0_addr  = 9'h0AA;
        step();
        bus.req0_valid        = 1'b0;
        bus.apb_xfer_done     = 1'b1;
        bus.PSLVERR           = 1'b1;
        bus.apb_read_data_out = 8'hE7;
        step();
        bus.apb_xfer_done     = 1'b0;
        bus.PSLVERR           = 1'b0;
        bus.apb_read_data_out = 8'h00;
        chk("t4_done0",  16'(bus.req0_done), 16'h1);
        chk("t4_err0",   16'(bus.req0_err), 16'h1);
        chk("t4_rdata0", 16'(bus.req0_rdata), 16'h0E7);
        step();

        // Test 5: timeout after 16 BUSY cycles
        xfer_cyc       = 0;
        bus.req1_valid = 1'b1;
        bus.req1_write = 1'b1;
        bus.req1_addr  = 9'h1FF;
        bus.req1_wdata = 8'h11;
        step();
        bus.req1_valid = 1'b0;
        chk("t5_wpaddr", 16'(bus.apb_write_paddr), 16'h1FF);
        for (int k = 0; k < 40; k++) begin
            if (bus.req1_done) break;
            step();
        end
        chk("t5_done1",    16'(bus.req1_done), 16'h1);
        chk("t5_err1",     16'(bus.req1_err), 16'h1);
        chk("t5_rdata1",   16'(bus.req1_rdata), 16'h0);
        chk("t5_xfer_cyc", 16'(xfer_cyc), 16'd16);
        step();

        // apb_xfer_done outside BUSY is ignored
        snap0 = d0_cnt;
        snap1 = d1_cnt;
        bus.apb_xfer_done = 1'b1;
        bus.PSLVERR       = 1'b1;
        step();
        bus.apb_xfer_done = 1'b0;
        bus.PSLVERR       = 1'b0;
        chk("ign_transfer", 16'(bus.transfer), 16'h0);
        step();
        chk("ign_d0", 16'(d0_cnt), 16'(snap0));
        chk("ign_d1", 16'(d1_cnt), 16'(snap1));
        chk("ign_err0", 16'(bus.req0_err), 16'h1);

        // Test 6: completion on the timeout cycle wins
        xfer_cyc       = 0;
        bus.req0_valid = 1'b1;
        bus.req0_write = 1'b0;
        bus.req0_addr  = 9'h0C3;
        step();
        bus.req0_valid = 1'b0;
        repeat (15) step();
        chk("t6_transfer", 16'(bus.transfer), 16'h1);
        bus.apb_xfer_done     = 1'b1;
        bus.apb_read_data_out = 8'h99;
        step();
        bus.apb_xfer_done     = 1'b0;
        bus.apb_read_data_out = 8'h00;
        chk("t6_done0",    16'(bus.req0_done), 16'h1);
        chk("t6_err0",     16'(bus.req0_err), 16'h0);
        chk("t6_rdata0",   16'(bus.req0_rdata), 16'h099);
        chk("t6_xfer_cyc", 16'(xfer_cyc), 16'd16);
        step();

        // Test 7: reset during BUSY, then req0 wins after release
        bus.req0_valid = 1'b1;
        bus.req0_write = 1'b1;
        bus.req0_addr  = 9'h033;
        bus.req0_wdata = 8'h44;
        #1;
        chk("t7_ready0", 16'(bus.req0_ready), 16'h1);
        step();
        bus.req1_valid = 1'b1;
        bus.req1_write = 1'b0;
        bus.req1_addr  = 9'h155;
        chk("t7_busy", 16'(bus.transfer), 16'h1);
        snap0   = d0_cnt;
        snap1   = d1_cnt;
        PRESETn = 1'b0;
        #1;
        chk("t7_rst_transfer", 16'(bus.transfer), 16'h0);
        chk("t7_rst_wpaddr",   16'(bus.apb_write_paddr), 16'h0);
        chk("t7_rst_ready",    16'({bus.req0_ready, bus.req1_ready}), 16'h0);
        chk("t7_rst_rdata0",   16'(bus.req0_rdata), 16'h0);
        repeat (3) step();
        chk("t7_no_done0", 16'(d0_cnt), 16'(snap0));
        chk("t7_no_done1", 16'(d1_cnt), 16'(snap1));
        PRESETn = 1'b1;
        #1;
        chk("t7_ready0_after", 16'(bus.req0_ready), 16'h1);
        chk("t7_ready1_after", 16'(bus.req1_ready), 16'h0);
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("t7_wpaddr", 16'(bus.apb_write_paddr), 16'h033);
        chk("t7_rw",     16'(bus.READ_WRITE), 16'h0);
        bus.apb_xfer_done = 1'b1;
        step();
        bus.apb_xfer_done = 1'b0;
        chk("t7_done0", 16'(bus.req0_done), 16'h1);
        chk("t7_done1", 16'(bus.req1_done), 16'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
